tlb_req_arbiter: RTL and testbench

TLB_REQ_ARBITER -- requirements
Module: tlb_req_arbiter

---
 rtl/tlb_req_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_tlb_req_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_req_arbiter.sv
// TLB request arbiter: serialises IFU/LSU lookups, flushes and PTW
// updates onto a single-ported TLB and keeps hit/miss statistics.
module tlb_req_arbiter #(
    parameter int ASID_W    = 16,
    parameter int VLEN      = 39,
    parameter int CONTENT_W = 66,
    parameter int UPD_W     = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                lu_valid_i,
    output logic [1:0]                lu_ready_o,
    input  logic [1:0][ASID_W-1:0]    lu_asid_i,
    input  logic [1:0][VLEN-1:0]      lu_vaddr_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic                      resp_id_o,
    output logic                      resp_hit_o,
    output logic [CONTENT_W-1:0]      resp_content_o,
    input  logic                      flush_valid_i,
    output logic                      flush_ready_o,
    input  logic [ASID_W-1:0]         flush_asid_i,
    input  logic [VLEN-1:0]           flush_vaddr_i,
    input  logic                      upd_valid_i,
    output logic                      upd_ready_o,
    input  logic [UPD_W-1:0]          upd_data_i,
    output logic                      tlb_lu_access_o,
    output logic [ASID_W-1:0]         tlb_lu_asid_o,
    output logic [VLEN-1:0]           tlb_lu_vaddr_o,
    input  logic                      tlb_lu_hit_i,
    input  logic [CONTENT_W-1:0]      tlb_lu_content_i,
    output logic                      tlb_flush_o,
    output logic [ASID_W-1:0]         tlb_flush_asid_o,
    output logic [VLEN-1:0]           tlb_flush_vaddr_o,
    output logic                      tlb_upd_valid_o,
    output logic [UPD_W-1:0]          tlb_upd_data_o,
    output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP,
        MAINT
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_q, last_d;
    logic                   id_q;
    logic [ASID_W-1:0]      asid_q;
    logic [VLEN-1:0]        vaddr_q;
    logic                   hit_q;
    logic [CONTENT_W-1:0]   content_q;
    logic                   is_flush_q;
    logic [ASID_W-1:0]      flush_asid_q;
    logic [VLEN-1:0]        flush_vaddr_q;
    logic [UPD_W-1:0]       upd_data_q;
    logic [31:0]            hit_cnt_q, hit_cnt_d;
    logic [31:0]            miss_cnt_q, miss_cnt_d;

    logic idle;
    logic gnt;
    logic flush_fire;
    logic upd_fire;
    logic lu_fire;

    assign idle       = (state_q == IDLE);
    assign flush_fire = idle & flush_valid_i;
    assign upd_fire   = idle & ~flush_valid_i & upd_valid_i;
    assign lu_fire    = idle & ~flush_valid_i & ~upd_valid_i & (|lu_valid_i);

    // Round-robin pick: the requester not served last wins a tie.
    always_comb begin
        gnt = 1'b0;
        if (&lu_valid_i) begin
            gnt = ~last_q;
        end else if (lu_valid_i[0]) begin
            gnt = 1'b0;
        end else begin
            gnt = 1'b1;
        end
    end

    assign flush_ready_o = idle;
    assign upd_ready_o   = idle & ~flush_valid_i;
    assign lu_ready_o    = lu_fire ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    // Next-state and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (flush_fire || upd_fire) begin
                    state_d = MAINT;
                end else if (lu_fire) begin
                    state_d = LOOKUP;
                    last_d  = gnt;
                end
            end
            LOOKUP: state_d = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            MAINT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; pointer resets to favour requester 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Operand capture on handshakes and result capture in LOOKUP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q          <= 1'b0;
            asid_q        <= '0;
            vaddr_q       <= '0;
            hit_q         <= 1'b0;
            content_q     <= '0;
            is_flush_q    <= 1'b0;
            flush_asid_q  <= '0;
            flush_vaddr_q <= '0;
            upd_data_q    <= '0;
        end else begin
            if (lu_fire) begin
                id_q    <= gnt;
                asid_q  <= lu_asid_i[gnt];
                vaddr_q <= lu_vaddr_i[gnt];
            end
            if (state_q == LOOKUP) begin
                hit_q     <= tlb_lu_hit_i;
                content_q <= tlb_lu_content_i;
            end
            if (flush_fire) begin
                is_flush_q    <= 1'b1;
                flush_asid_q  <= flush_asid_i;
                flush_vaddr_q <= flush_vaddr_i;
            end else if (upd_fire) begin
                is_flush_q <= 1'b0;
                upd_data_q <= upd_data_i;
            end
        end
    end

    // Saturating statistics, bumped on the captured lookup result.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (tlb_lu_hit_i && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!tlb_lu_hit_i && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign tlb_lu_access_o   = (state_q == LOOKUP) & ~rst_i;
    assign tlb_lu_asid_o     = asid_q;
    assign tlb_lu_vaddr_o    = vaddr_q;
    assign tlb_flush_o       = (state_q == MAINT) & is_flush_q & ~rst_i;
    assign tlb_flush_asid_o  = flush_asid_q;
    assign tlb_flush_vaddr_o = flush_vaddr_q;
    assign tlb_upd_valid_o   = (state_q == MAINT) & ~is_flush_q & ~rst_i;
    assign tlb_upd_data_o    = upd_data_q;

    assign resp_valid_o   = (state_q == RESP) & ~rst_i;
    assign resp_id_o      = id_q;
    assign resp_hit_o     = hit_q;
    assign resp_content_o = hit_q ? content_q : '0;

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_tlb_req_arbiter.sv
// Directed and randomized checks of tlb_req_arbiter against a
// transaction-level model of its arbitration, latency and counters.
module tb_tlb_req_arbiter;

    localparam int ASID_W    = 16;
    localparam int VLEN      = 39;
    localparam int CONTENT_W = 66;
    localparam int UPD_W     = 128;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             lu_valid;
    logic [1:0]             lu_ready;
    logic [1:0][ASID_W-1:0] lu_asid;
    logic [1:0][VLEN-1:0]   lu_vaddr;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_id;
    logic                   resp_hit;
    logic [CONTENT_W-1:0]   resp_content;
    logic                   flush_valid;
    logic                   flush_ready;
    logic [ASID_W-1:0]      flush_asid;
    logic [VLEN-1:0]        flush_vaddr;
    logic                   upd_valid;
    logic                   upd_ready;
    logic [UPD_W-1:0]       upd_data;
    logic                   tlb_access;
    logic [ASID_W-1:0]      tlb_asid;
    logic [VLEN-1:0]        tlb_vaddr;
    logic                   tlb_hit;
    logic [CONTENT_W-1:0]   tlb_content;
    logic                   tlb_flush;
    logic [ASID_W-1:0]      tlb_flush_asid;
    logic [VLEN-1:0]        tlb_flush_vaddr;
    logic                   tlb_upd_valid;
    logic [UPD_W-1:0]       tlb_upd_data;
    logic [31:0]            hit_cnt;
    logic [31:0]            miss_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state
    int          last_served;
    longint      m_hits;
    longint      m_misses;

    tlb_req_arbiter #(
        .ASID_W(ASID_W), .VLEN(VLEN),
        .CONTENT_W(CONTENT_W), .UPD_W(UPD_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .lu_valid_i(lu_valid),
        .lu_ready_o(lu_ready),
        .lu_asid_i(lu_asid),
        .lu_vaddr_i(lu_vaddr),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_id_o(resp_id),
        .resp_hit_o(resp_hit),
        .resp_content_o(resp_content),
        .flush_valid_i(flush_valid),
        .flush_ready_o(flush_ready),
        .flush_asid_i(flush_asid),
        .flush_vaddr_i(flush_vaddr),
        .upd_valid_i(upd_valid),
        .upd_ready_o(upd_ready),
        .upd_data_i(upd_data),
        .tlb_lu_access_o(tlb_access),
        .tlb_lu_asid_o(tlb_asid),
        .tlb_lu_vaddr_o(tlb_vaddr),
        .tlb_lu_hit_i(tlb_hit),
        .tlb_lu_content_i(tlb_content),
        .tlb_flush_o(tlb_flush),
        .tlb_flush_asid_o(tlb_flush_asid),
        .tlb_flush_vaddr_o(tlb_flush_vaddr),
        .tlb_upd_valid_o(tlb_upd_valid),
        .tlb_upd_data_o(tlb_upd_data),
        .hit_cnt_o(hit_cnt),
        .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        lu_valid    = 2'b00;
        flush_valid = 1'b0;
        upd_valid   = 1'b0;
        resp_ready  = 1'b0;
    endtask

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return 1 - last_served;
        if (v[0]) return 0;
        return 1;
    endfunction

    function automatic longint sat(input longint x);
        if (x > 64'h0000_0000_FFFF_FFFF) return 64'h0000_0000_FFFF_FFFF;
        return x;
    endfunction

    logic [95:0]  r96;
    logic [63:0]  r64;
    logic [1:0]   lv;
    logic         fv;
    logic         uv;
    logic         h;
    logic [CONTENT_W-1:0] c;
    int           g;
    int           hs_prev;
    int           wait_n;
    logic [1:0]   exp_rdy;

    initial begin
        rst = 1'b1;
        quiet();
        lu_asid     = '0;
        lu_vaddr    = '0;
        flush_asid  = '0;
        flush_vaddr = '0;
        upd_data    = '0;
        tlb_hit     = 1'b0;
        tlb_content = '0;
        last_served = 1;
        m_hits      = 0;
        m_misses    = 0;
        @(negedge clk);
        step();
        step();

        // Reset values
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_content", resp_content, 0);
        chk("rst_access", tlb_access, 0);
        chk("rst_flush", tlb_flush, 0);
        chk("rst_upd", tlb_upd_valid, 0);
        chk("rst_ops", {tlb_asid, tlb_vaddr, tlb_flush_asid}, 0);
        chk("rst_upd_data", tlb_upd_data, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        step();

        // IFU hit
        lu_valid    = 2'b01;
        lu_asid[0]  = 16'd5;
        lu_vaddr[0] = 39'h1000;
        #1;
        chk("ifu_ready", lu_ready, 2'b01);
        chk("ifu_flush_ready", flush_ready, 1);
        step();
        lu_valid    = 2'b00;
        tlb_hit     = 1'b1;
        tlb_content = 66'h3_0000_00AB;
        chk("ifu_access", tlb_access, 1);
        chk("ifu_asid", tlb_asid, 5);
        chk("ifu_vaddr", tlb_vaddr, 39'h1000);
        chk("ifu_no_resp_yet", resp_valid, 0);
        step();
        tlb_content = '0;
        m_hits++;
        last_served = 0;
        chk("ifu_resp_valid", resp_valid, 1);
        chk("ifu_resp_id", resp_id, 0);
        chk("ifu_resp_hit", resp_hit, 1);
        chk("ifu_resp_content", resp_content, 66'h3_0000_00AB);
        chk("ifu_hit_cnt", hit_cnt, m_hits);
        chk("ifu_access_off", tlb_access, 0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // LSU miss, stalled response, flush waits behind it
        lu_valid    = 2'b10;
        lu_asid[1]  = 16'd7;
        lu_vaddr[1] = 39'h2000;
        #1;
        chk("lsu_ready", lu_ready, 2'b10);
        step();
        lu_valid    = 2'b00;
        tlb_hit     = 1'b0;
        tlb_content = '1;
        flush_valid = 1'b1;
        flush_asid  = 16'h33;
        flush_vaddr = 39'h4_5000;
        chk("lsu_access", tlb_access, 1);
        chk("lsu_flush_wait", flush_ready, 0);
        step();
        m_misses++;
        last_served = 1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", resp_valid, 1);
            chk("stall_content", resp_content, 0);
            chk("stall_id", resp_id, 1);
            chk("stall_hit", resp_hit, 0);
            chk("stall_flush_ready", flush_ready, 0);
            chk("stall_no_strobe", {tlb_flush, tlb_access}, 0);
            step();
        end
        resp_ready = 1'b1;
        chk("stall_last_valid", resp_valid, 1);
        chk("miss_cnt_1", miss_cnt, m_misses);
        step();
        resp_ready = 1'b0;
        chk("flush_ready_idle", flush_ready, 1);
        step();
        flush_valid = 1'b0;
        chk("flush_strobe", tlb_flush, 1);
        chk("flush_upd_off", tlb_upd_valid, 0);
        chk("flush_asid", tlb_flush_asid, 16'h33);
        chk("flush_vaddr", tlb_flush_vaddr, 39'h4_5000);
        step();
        chk("flush_strobe_off", tlb_flush, 0);
        chk("flush_back_idle", flush_ready, 1);

        // Round-robin, back-to-back
        lu_valid   = 2'b11;
        resp_ready = 1'b1;
        tlb_hit    = 1'b1;
        hs_prev    = -1;
        for (int i = 0; i < 4; i++) begin
            g = pick(lu_valid);
            exp_rdy = (g == 0) ? 2'b01 : 2'b10;
            #1;
            chk("rr_ready", lu_ready, exp_rdy);
            chk("rr_order", g, i % 2);
            if (hs_prev >= 0) chk("rr_spacing", cyc - hs_prev, 3);
            hs_prev = cyc;
            step();
            step();
            m_hits++;
            last_served = g;
            chk("rr_resp_id", resp_id, g);
            chk("rr_resp_valid", resp_valid, 1);
            step();
        end
        quiet();

        // Flush > update > lookup
        flush_valid = 1'b1;
        upd_valid   = 1'b1;
        upd_data    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
        lu_valid    = 2'b11;
        #1;
        chk("pri_flush_ready", flush_ready, 1);
        chk("pri_upd_ready", upd_ready, 0);
        chk("pri_lu_ready0", lu_ready, 0);
        step();
        flush_valid = 1'b0;
        chk("pri_flush_first", tlb_flush, 1);
        chk("pri_upd_not_yet", tlb_upd_valid, 0);
        step();
        chk("pri_upd_ready2", upd_ready, 1);
        chk("pri_lu_ready1", lu_ready, 0);
        step();
        upd_valid = 1'b0;
        chk("pri_upd_strobe", tlb_upd_valid, 1);
        chk("pri_flush_off", tlb_flush, 0);
        chk("pri_upd_data", tlb_upd_data,
            128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        step();
        chk("pri_upd_off", tlb_upd_valid, 0);
        g = pick(lu_valid);
        chk("pri_grant0", lu_ready, (g == 0) ? 2'b01 : 2'b10);
        chk("pri_grant0_model", g, 0);
        step();
        lu_valid = 2'b00;
        step();
        m_hits++;
        last_served = g;
        chk("pri_resp_id", resp_id, 0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Miss counter saturation
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        step();
        release dut.miss_cnt_q;
        step();
        m_misses = 64'h0000_0000_FFFF_FFFE;
        chk("sat_preset", miss_cnt, m_misses);
        tlb_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lu_valid = 2'b01;
            #1;
            chk("sat_ready", lu_ready, 2'b01);
            step();
            lu_valid = 2'b00;
            step();
            m_misses = sat(m_misses + 1);
            last_served = 0;
            chk("sat_miss_cnt", miss_cnt, m_misses);
            chk("sat_hit_cnt", hit_cnt, m_hits);
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
        end

        // Reset during LOOKUP
        lu_valid = 2'b10;
        step();
        lu_valid = 2'b00;
        chk("rstlk_access", tlb_access, 1);
        rst = 1'b1;
        step();
        chk("rstlk_resp_valid", resp_valid, 0);
        chk("rstlk_access_off", tlb_access, 0);
        chk("rstlk_hit_cnt", hit_cnt, 0);
        chk("rstlk_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        m_hits = 0;
        m_misses = 0;
        last_served = 1;
        step();
        chk("rstlk_still_quiet", resp_valid, 0);
        lu_valid = 2'b01;
        #1;
        chk("rstlk_ifu_ready", lu_ready, 2'b01);
        step();
        lu_valid = 2'b00;
        last_served = 0;
        step();
        m_misses++;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            fv = ($urandom_range(0, 5) == 0);
            uv = ($urandom_range(0, 5) == 0);
            lv = 2'($urandom_range(0, 3));
            flush_valid = fv;
            upd_valid   = uv;
            lu_valid    = lv;
            for (int k = 0; k < 2; k++) begin
                r64 = {$urandom(), $urandom()};
                lu_asid[k]  = r64[63:48];
                lu_vaddr[k] = r64[38:0];
            end
            r64 = {$urandom(), $urandom()};
            flush_asid  = r64[63:48];
            flush_vaddr = r64[38:0];
            upd_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            chk("rnd_flush_ready", flush_ready, 1);
            chk("rnd_upd_ready", upd_ready, !fv);
            if (fv) begin
                chk("rnd_f_lu_ready", lu_ready, 0);
                step();
                chk("rnd_f_strobe", {tlb_flush, tlb_upd_valid}, 2'b10);
                chk("rnd_f_asid", tlb_flush_asid, flush_asid);
                chk("rnd_f_vaddr", tlb_flush_vaddr, flush_vaddr);
                quiet();
                step();
            end else if (uv) begin
                chk("rnd_u_lu_ready", lu_ready, 0);
                step();
                chk("rnd_u_strobe", {tlb_flush, tlb_upd_valid}, 2'b01);
                chk("rnd_u_data", tlb_upd_data, upd_data);
                quiet();
                step();
            end else if (lv != 2'b00) begin
                g = pick(lv);
                chk("rnd_l_ready", lu_ready, (g == 0) ? 2'b01 : 2'b10);
                step();
                quiet();
                last_served = g;
                h = 1'($urandom_range(0, 1));
                r96 = {$urandom(), $urandom(), $urandom()};
                c = r96[CONTENT_W-1:0];
                tlb_hit = h;
                tlb_content = c;
                chk("rnd_l_access", tlb_access, 1);
                chk("rnd_l_asid", tlb_asid, lu_asid[g]);
                chk("rnd_l_vaddr", tlb_vaddr, lu_vaddr[g]);
                step();
                tlb_content = '1;
                if (h) m_hits = sat(m_hits + 1);
                else m_misses = sat(m_misses + 1);
                wait_n = $urandom_range(0, 3);
                for (int w = 0; w <= wait_n; w++) begin
                    resp_ready = (w == wait_n);
                    chk("rnd_r_valid", resp_valid, 1);
                    chk("rnd_r_id", resp_id, g);
                    chk("rnd_r_hit", resp_hit, h);
                    chk("rnd_r_content", resp_content, h ? c : '0);
                    chk("rnd_r_hits", hit_cnt, m_hits);
                    chk("rnd_r_misses", miss_cnt, m_misses);
                    step();
                end
                resp_ready = 1'b0;
                chk("rnd_r_done", resp_valid, 0);
            end else begin
                chk("rnd_idle_ready", lu_ready, 0);
                step();
                chk("rnd_idle_quiet",
                    {tlb_access, tlb_flush, tlb_upd_valid, resp_valid}, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
